// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned NMin = 2;
    localparam int unsigned NMax = 32;

    // Bit-counter width; never zero so the counter stays a real vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fa_slice.sv
// One-bit full-adder slice: sum and majority carry of three inputs.
module fa_slice (
    input  logic x_i,
    input  logic y_i,
    input  logic z_i,
    output logic s_o,
    output logic c_o
);

    always_comb begin
        s_o = x_i ^ y_i ^ z_i;
        c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one shared full-adder slice, a carry flop and an
// IDLE/SHIFT/DONE controller. All outputs are registered.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_t          state_q;
    logic [N-1:0]    a_sr_q;
    logic [N-1:0]    b_sr_q;
    logic [N-1:0]    s_sr_q;
    logic [N-1:0]    sum_q;
    logic [CntW-1:0] cnt_q;
    logic            carry_q;
    logic            cout_q;
    logic            busy_q;
    logic            done_q;

    logic            slice_s;
    logic            slice_c;
    logic [N-1:0]    s_sr_d;

    fa_slice u_fa_slice (
        .x_i (a_sr_q[0]),
        .y_i (b_sr_q[0]),
        .z_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    // New sum bit enters at the MSB so bit 0 lands in place after N shifts.
    always_comb begin
        s_sr_d = {slice_s, s_sr_q[N-1:1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_sr_q  <= a_i;
                        b_sr_q  <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry_q <= slice_c;
                    s_sr_q  <= s_sr_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    if (cnt_q == CntLast) begin
                        sum_q   <= s_sr_d;
                        cout_q  <= slice_c;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised self-checking bench for serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    int unsigned  n_checks;
    int unsigned  n_errors;
    logic [N-1:0] prev_sum;
    logic         prev_cout;

    serial_adder_ctrl #(
        .N (N)
    ) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one addition from IDLE; noise pulses start during SHIFT and DONE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                          input bit noise);
        int          edges;
        logic [N:0]  full;
        full  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        tick();
        start = 1'b0;
        a_in  = N'($urandom);
        b_in  = N'($urandom);
        cin   = 1'($urandom);
        check("busy_on_accept", busy, 1);
        check("done_on_accept", done, 0);
        edges = 0;
        while (!done && edges < 3 * N) begin
            if (noise) begin
                start = (edges == 3);
                a_in  = 8'h77;
                b_in  = 8'h11;
            end
            tick();
            edges++;
            if (!done && edges == N / 2) begin
                check("sum_hold_shift", sum, prev_sum);
                check("cout_hold_shift", cout, prev_cout);
                check("busy_in_shift", busy, 1);
            end
        end
        check("done_latency", edges, N);
        check("sum", sum, full[N-1:0]);
        check("cout", cout, full[N]);
        check("busy_in_done", busy, 1);
        start = noise;
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_fall", busy, 0);
        check("sum_hold_idle", sum, full[N-1:0]);
        prev_sum  = full[N-1:0];
        prev_cout = full[N];
        // Make sure a noise request during DONE was not executed.
        tick();
        check("no_queued_op", busy, 0);
    endtask

    initial begin
        int last_done;
        int pulses;
        n_checks  = 0;
        n_errors  = 0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_sum", sum, 0);
            check("idle_cout", cout, 0);
        end

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        check("ignored_request", sum, 8'h30);

        for (int i = 0; i < 25; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        // Back-to-back with start held high.
        start     = 1'b1;
        a_in      = 8'h01;
        b_in      = 8'h01;
        cin       = 1'b0;
        last_done = -1;
        pulses    = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            tick();
            if (done) begin
                if (last_done >= 0) check("b2b_period", cyc - last_done, N + 2);
                check("b2b_sum", sum, 8'h02);
                last_done = cyc;
                pulses++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 4);
        for (int i = 0; i < 3 * N && busy; i++) tick();
        check("b2b_drain", busy, 0);

        // Abort mid-operation with an asynchronous reset.
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        cin   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
